// File: rtl/instr_dispatch_if.sv
// Instruction dispatch bus: upstream push handshake plus the operation
// presented to the downstream register-file controller and its completion.
interface instr_dispatch_if;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] in_instr;
    logic [4:0]  read1;
    logic [4:0]  read2;
    logic [4:0]  write;
    logic [15:0] data;
    logic [2:0]  validity;
    logic        op_valid;
    logic        indicator;

    // Driver side: produces instructions and completion, observes the operation
    modport master (
        output in_valid, in_instr, indicator,
        input  in_ready, read1, read2, write, data, validity, op_valid
    );

    // Dispatcher side
    modport slave (
        input  in_valid, in_instr, indicator,
        output in_ready, read1, read2, write, data, validity, op_valid
    );
endinterface

// File: rtl/instr_dispatch.sv
// Instruction dispatcher: a small FIFO of 34-bit instructions feeding a
// two-state issue FSM. Each popped instruction is held on the outputs until
// the controller signals completion or the wait counter expires.
module instr_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instr_dispatch_if.slave          bus,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               issued_count,
    output logic                     timeout_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [33:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, empty, push, pop;
    logic [33:0]      head;

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [4:0]       read1_q, read2_q, write_q;
    logic [15:0]      data_q;
    logic [2:0]       validity_q;
    logic             op_valid_q;
    logic [7:0]       issued_q;
    logic             timeout_err_q;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    // in_ready looks only at the registered level, so a full FIFO refuses
    // a push even on the edge where the FSM pops.
    assign push  = bus.in_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;
    assign head  = mem_q[rd_ptr_q];

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents are only meaningful behind the level count
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_instr;
    end

    // Issue FSM with registered operation outputs and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            read1_q       <= '0;
            read2_q       <= '0;
            write_q       <= '0;
            data_q        <= '0;
            validity_q    <= '0;
            op_valid_q    <= 1'b0;
            issued_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        validity_q <= head[33:31];
                        read1_q    <= head[30:26];
                        read2_q    <= head[25:21];
                        write_q    <= head[20:16];
                        data_q     <= head[15:0];
                        op_valid_q <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Completion takes priority over an expiring counter
                    if (bus.indicator) begin
                        op_valid_q <= 1'b0;
                        issued_q   <= issued_q + 8'd1;
                        state_q    <= S_IDLE;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        op_valid_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    op_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = !full;
    assign bus.read1    = read1_q;
    assign bus.read2    = read2_q;
    assign bus.write    = write_q;
    assign bus.data     = data_q;
    assign bus.validity = validity_q;
    assign bus.op_valid = op_valid_q;
    assign busy         = op_valid_q || !empty;
    assign fifo_level   = level_q;
    assign issued_count = issued_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Testbench for instr_dispatch: directed scenarios followed by a randomized
// run, every cycle compared against a queue-based reference model.
module tb_instr_dispatch;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [2:0] fifo_level;
    logic [7:0] issued_count;
    logic       timeout_err;

    instr_dispatch_if bus();

    instr_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .issued_count (issued_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: queued instructions, the live one and its age
    logic [33:0] mq[$];
    logic [33:0] m_cur;
    bit          m_live;
    int          m_age;
    int          m_done;
    bit          m_terr;

    function automatic logic [33:0] mk(logic [2:0] op, logic [4:0] rs1, logic [4:0] rs2,
                                       logic [4:0] rd, logic [15:0] imm);
        return {op, rs1, rs2, rd, imm};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_cur  = '0;
        m_live = 0;
        m_age  = 0;
        m_done = 0;
        m_terr = 0;
    endtask

    // One rising edge of the model, using inputs as they stand before the edge
    task automatic model_edge();
        bit accept;
        accept = bus.in_valid && (mq.size() < DEPTH);
        if (!m_live) begin
            if (mq.size() > 0) begin
                m_cur  = mq.pop_front();
                m_live = 1;
                m_age  = 0;
            end
        end else begin
            m_age++;
            if (bus.indicator) begin
                m_live = 0;
                m_done++;
            end else if (m_age == TIMEOUT) begin
                m_live = 0;
                m_terr = 1;
            end
        end
        if (accept) mq.push_back(bus.in_instr);
    endtask

    task automatic check_all();
        check("in_ready",     32'(bus.in_ready),  32'(mq.size() < DEPTH));
        check("fifo_level",   32'(fifo_level),    32'(mq.size()));
        check("op_valid",     32'(bus.op_valid),  32'(m_live));
        check("validity",     32'(bus.validity),  32'(m_cur[33:31]));
        check("read1",        32'(bus.read1),     32'(m_cur[30:26]));
        check("read2",        32'(bus.read2),     32'(m_cur[25:21]));
        check("write",        32'(bus.write),     32'(m_cur[20:16]));
        check("data",         32'(bus.data),      32'(m_cur[15:0]));
        check("busy",         32'(busy),          32'(m_live || (mq.size() != 0)));
        check("issued_count", 32'(issued_count),  32'(m_done % 256));
        check("timeout_err",  32'(timeout_err),   32'(m_terr));
    endtask

    task automatic tick();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Assert reset between edges and check the outputs before any clock
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        bus.in_valid  = 1'b0;
        bus.indicator = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int cyc;
        int pushed;
        int n;
        bit took;
        bit prev_ov;
        logic [2:0] ops[$];

        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.indicator = 1'b0;
        model_reset();
        #2;
        check_all();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single operation with completion 20 edges after the push
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd5, 5'd3, 5'd4, 5'd7, 16'd0);
        tick();
        check("s1_level_after_push", 32'(fifo_level), 32'd1);
        check("s1_opv_at_push", 32'(bus.op_valid), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        check("s1_opv", 32'(bus.op_valid), 32'd1);
        check("s1_validity", 32'(bus.validity), 32'd5);
        check("s1_read1", 32'(bus.read1), 32'd3);
        check("s1_read2", 32'(bus.read2), 32'd4);
        check("s1_write", 32'(bus.write), 32'd7);
        repeat (18) tick();
        bus.indicator = 1'b1;
        tick();
        bus.indicator = 1'b0;
        check("s1_opv_done", 32'(bus.op_valid), 32'd0);
        check("s1_issued", 32'(issued_count), 32'd1);

        // Completion on the last WAIT cycle beats the timeout
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd2, 5'd1, 5'd1, 5'd1, 16'hBEEF);
        tick();
        bus.in_valid = 1'b0;
        tick();
        repeat (31) tick();
        check("s2_still_live", 32'(bus.op_valid), 32'd1);
        bus.indicator = 1'b1;
        tick();
        bus.indicator = 1'b0;
        check("s2_issued", 32'(issued_count), 32'd2);
        check("s2_no_timeout", 32'(timeout_err), 32'd0);

        // Indicator while idle has no effect
        bus.indicator = 1'b1;
        repeat (3) tick();
        bus.indicator = 1'b0;
        check("idle_ind_ignored", 32'(issued_count), 32'd2);

        // Fill the FIFO behind a live operation
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = mk(3'(i + 1), 5'(i), 5'(i + 1), 5'(i + 2), 16'(16'h100 + i));
            tick();
        end
        check("s3_level_full", 32'(fifo_level), 32'd4);
        check("s3_in_ready", 32'(bus.in_ready), 32'd0);
        check("s3_live_first", 32'(bus.validity), 32'd1);
        bus.in_instr = mk(3'd6, 5'd31, 5'd30, 5'd29, 16'hCAFE);
        repeat (3) tick();
        check("s3_held", 32'(fifo_level), 32'd4);
        bus.indicator = 1'b1;
        tick();
        bus.indicator = 1'b0;
        tick();
        check("s3_pop_refuses_push", 32'(fifo_level), 32'd3);
        check("s3_second_issued", 32'(bus.validity), 32'd2);
        tick();
        bus.in_valid = 1'b0;
        check("s3_held_accepted", 32'(fifo_level), 32'd4);

        // Second op times out after TIMEOUT WAIT cycles
        cyc = 1;
        while (bus.op_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("s4_timeout_cycles", 32'(cyc), 32'(TIMEOUT));
        check("s4_timeout_err", 32'(timeout_err), 32'd1);
        check("s4_issued_same", 32'(issued_count), 32'd3);
        tick();
        check("s4_next_issued", 32'(bus.op_valid), 32'd1);
        check("s4_next_validity", 32'(bus.validity), 32'd3);
        check("s4_queued", 32'(fifo_level), 32'd3);

        // Reset mid-WAIT with three entries queued
        async_reset();
        repeat (5) tick();
        check("s5_no_stale_op", 32'(bus.op_valid), 32'd0);
        check("s5_level", 32'(fifo_level), 32'd0);
        check("s5_terr_cleared", 32'(timeout_err), 32'd0);

        // Ops 0..7 issue in push order across pointer wrap
        pushed  = 0;
        n       = 0;
        prev_ov = 1'b0;
        while (ops.size() < 8 && n < 300) begin
            bus.in_valid  = (pushed < 8);
            bus.in_instr  = mk(3'(pushed), 5'(pushed), 5'(pushed + 8), 5'(pushed + 16), 16'(pushed * 3));
            bus.indicator = bus.op_valid;
            took = bus.in_valid && bus.in_ready;
            tick();
            if (took) pushed++;
            if (bus.op_valid && !prev_ov) ops.push_back(bus.validity);
            prev_ov = bus.op_valid;
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.indicator = 1'b0;
        check("s6_issue_count", 32'(ops.size()), 32'd8);
        for (int i = 0; i < ops.size(); i++) check("s6_order", 32'(ops[i]), 32'(i));

        // Random traffic until 256 completions since reset
        n = 0;
        while (m_done < 256 && n < 20000) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_instr  = {2'($urandom), $urandom};
            bus.indicator = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.indicator = 1'b0;
        check("s7_within_bound", 32'(n < 20000), 32'd1);
        check("s7_issued_wrapped", 32'(issued_count), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
